// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out handshake shared by UART_RX, the word packer and the Crypter.
interface uart_rx_word_packer_if #(
  parameter int WORD_BYTES = 4
);
  logic                    rx_done_tick;
  logic [7:0]              rx_data;
  logic                    clear_flag;
  logic                    flag;
  logic [8*WORD_BYTES-1:0] data_out;
  logic                    eot;
  logic                    overrun;

  modport master (
    output rx_done_tick, rx_data, clear_flag,
    input  flag, data_out, eot, overrun
  );

  modport slave (
    input  rx_done_tick, rx_data, clear_flag,
    output flag, data_out, eot, overrun
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes big-endian into words for the Crypter, with one
// word of pending storage, word-boundary EOT detection and sticky overrun.
//
// state    | meaning
// ST_EMPTY | no unconsumed word on data_out
// ST_READY | data_out holds an unconsumed word, assembly register free
// ST_FULL  | data_out unconsumed and a complete word waits in the assembly register
module uart_rx_word_packer #(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] EOT_BYTE   = 8'h04
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_word_packer_if.slave bus
);

  localparam int            W        = 8*WORD_BYTES;
  localparam int            CW       = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BYTES-1);

  // encoding is {pend, flag}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_READY = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_asm;
  logic [W-1:0]  r_data_out;
  logic [CW-1:0] r_cnt;
  logic          r_eot;
  logic          r_overrun;

  logic          w_pend;
  logic          w_flag;
  logic          w_clr_full;
  logic          w_pend_eff;
  logic          w_take;
  logic          w_is_eot;
  logic          w_store;
  logic          w_complete;
  logic          w_load_new;
  logic          w_drop;
  logic [W-1:0]  w_word;

  // A clear that frees the pending word is applied before the byte of the same cycle.
  assign w_clr_full = bus.clear_flag && w_pend;
  assign w_pend_eff = w_pend && !bus.clear_flag;
  assign w_take     = bus.rx_done_tick && !w_pend_eff;
  assign w_is_eot   = w_take && (r_cnt == '0) && (bus.rx_data == EOT_BYTE);
  assign w_store    = w_take && !w_is_eot;
  assign w_complete = w_store && (r_cnt == CNT_LAST);
  assign w_load_new = w_complete && (!w_flag || bus.clear_flag);
  assign w_drop     = bus.rx_done_tick && w_pend_eff;
  assign w_word     = {r_asm[W-9:0], bus.rx_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_complete) w_state_nxt = ST_READY;
      ST_READY: begin
        if (w_complete)          w_state_nxt = bus.clear_flag ? ST_READY : ST_FULL;
        else if (bus.clear_flag) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (bus.clear_flag) w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_pend       = r_state[1];
    w_flag       = r_state[0];
    bus.flag     = r_state[0];
    bus.data_out = r_data_out;
    bus.eot      = r_eot;
    bus.overrun  = r_overrun;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_eot      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_store) begin
        r_asm <= w_word;
        r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
      end
      if (w_load_new) begin
        r_data_out <= w_word;
      end else if (w_clr_full) begin
        r_data_out <= r_asm;
      end
      if (w_is_eot) begin
        r_eot <= 1'b1;
      end else if (w_store && (r_cnt == '0)) begin
        r_eot <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  a_no_pend_without_flag : assert property (@(posedge clk) disable iff (!rst) !(w_pend && !w_flag));

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Drives a 4-byte and a 2-byte packer with the same stimulus and checks both
// every cycle against a byte-queue model of the packing rules.
module tb_uart_rx_word_packer;

  localparam logic [7:0] EOT = 8'h04;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = 8'h00;
  bit         chk_en = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_word_packer_if #(.WORD_BYTES(4)) if4 ();
  uart_rx_word_packer_if #(.WORD_BYTES(2)) if2 ();

  assign if4.rx_done_tick = tick;
  assign if4.rx_data      = din;
  assign if4.clear_flag   = clr;
  assign if2.rx_done_tick = tick;
  assign if2.rx_data      = din;
  assign if2.clear_flag   = clr;

  uart_rx_word_packer #(.WORD_BYTES(4), .EOT_BYTE(EOT)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  uart_rx_word_packer #(.WORD_BYTES(2), .EOT_BYTE(EOT)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Model: partial word as a growing integer plus byte count, one held word.
  logic [63:0] m_dout[2];
  logic [63:0] m_held[2];
  logic [63:0] m_part[2];
  int          m_n[2];
  bit          m_flag[2];
  bit          m_pend[2];
  bit          m_eot[2];
  bit          m_ovr[2];

  task automatic model_step(input int i, input int wb);
    if (!rst) begin
      m_dout[i] = '0; m_held[i] = '0; m_part[i] = '0; m_n[i] = 0;
      m_flag[i] = 0;  m_pend[i] = 0;  m_eot[i] = 0;   m_ovr[i] = 0;
    end else begin
      if (clr) begin
        if (m_pend[i]) begin
          m_dout[i] = m_held[i];
          m_pend[i] = 0;
        end else begin
          m_flag[i] = 0;
        end
      end
      if (tick) begin
        if (m_pend[i]) begin
          m_ovr[i] = 1;
        end else if (m_n[i] == 0 && din == EOT) begin
          m_eot[i] = 1;
        end else begin
          if (m_n[i] == 0) m_eot[i] = 0;
          m_part[i] = (m_part[i] << 8) | 64'(din);
          m_n[i]++;
          if (m_n[i] == wb) begin
            if (!m_flag[i]) begin
              m_dout[i] = m_part[i];
              m_flag[i] = 1;
            end else begin
              m_held[i] = m_part[i];
              m_pend[i] = 1;
            end
            m_part[i] = '0;
            m_n[i]    = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4);
    model_step(1, 2);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("w4_flag",    64'(if4.flag),     64'(m_flag[0]));
      chk("w4_data",    64'(if4.data_out), m_dout[0]);
      chk("w4_eot",     64'(if4.eot),      64'(m_eot[0]));
      chk("w4_overrun", 64'(if4.overrun),  64'(m_ovr[0]));
      chk("w2_flag",    64'(if2.flag),     64'(m_flag[1]));
      chk("w2_data",    64'(if2.data_out), m_dout[1]);
      chk("w2_eot",     64'(if2.eot),      64'(m_eot[1]));
      chk("w2_overrun", 64'(if2.overrun),  64'(m_ovr[1]));
    end
  end

  task automatic cyc(input logic t, input logic [7:0] d, input logic c);
    tick = t;
    din  = d;
    clr  = c;
    @(posedge clk);
    #1;
    tick = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic outputs_zero(input string nm);
    chk({nm, "_w4_flag"}, 64'(if4.flag),     64'd0);
    chk({nm, "_w4_data"}, 64'(if4.data_out), 64'd0);
    chk({nm, "_w4_eot"},  64'(if4.eot),      64'd0);
    chk({nm, "_w4_ovr"},  64'(if4.overrun),  64'd0);
    chk({nm, "_w2_data"}, 64'(if2.data_out), 64'd0);
    chk({nm, "_w2_flag"}, 64'(if2.flag),     64'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    outputs_zero("reset");
    rst = 1'b1;

    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("first_flag", 64'(if4.flag), 64'd1);
    chk("first_data", 64'(if4.data_out), 64'hDEADBEEF);
    chk("model_first_data", m_dout[0], 64'hDEADBEEF);
    cyc(1'b0, 8'h00, 1'b0);

    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    cyc(1'b0, 8'h00, 1'b0);
    chk("pend_data_held", 64'(if4.data_out), 64'hDEADBEEF);
    chk("pend_flag", 64'(if4.flag), 64'd1);
    send(8'h55);
    chk("overrun_set", 64'(if4.overrun), 64'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pend_release_data", 64'(if4.data_out), 64'h11223344);
    chk("pend_release_flag", 64'(if4.flag), 64'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("clear_flag", 64'(if4.flag), 64'd0);

    send(EOT);
    chk("eot_set", 64'(if4.eot), 64'd1);
    chk("eot_no_flag", 64'(if4.flag), 64'd0);
    send(8'h01);
    chk("eot_cleared", 64'(if4.eot), 64'd0);
    send(8'h04); send(8'h02); send(8'h03);
    chk("eot_mid_word_data", 64'(if4.data_out), 64'h01040203);
    chk("model_eot_mid_word", m_dout[0], 64'h01040203);

    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'hA1); send(8'hA2); send(8'hA3);
    cyc(1'b1, 8'hA4, 1'b1);
    chk("coinc_flag", 64'(if4.flag), 64'd1);
    chk("coinc_data", 64'(if4.data_out), 64'hA1A2A3A4);
    chk("coinc_overrun", 64'(if4.overrun), 64'd0);

    send(8'h55); send(8'h66);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    outputs_zero("midword_reset");
    cyc(1'b1, 8'h77, 1'b0);
    outputs_zero("reset_beats_tick");
    rst = 1'b1;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("after_reset_data", 64'(if4.data_out), 64'hAABBCCDD);

    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    send(8'h12); send(8'h34);
    chk("w2_word_data", 64'(if2.data_out), 64'h1234);
    chk("w2_word_flag", 64'(if2.flag), 64'd1);
    chk("w2_w4_flag_idle", 64'(if4.flag), 64'd0);

    for (int k = 0; k < 4000; k++) begin
      rst  = ($urandom_range(0, 599) != 0);
      tick = ($urandom_range(0, 1) == 1);
      din  = ($urandom_range(0, 4) == 0) ? EOT : 8'($urandom);
      clr  = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
    clr  = 1'b0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
